// File: rtl/rk16_pkg.sv
// Shared RK16 definitions: alu select codes, sequencer state encoding and
// the shift-class decoder used by both the sequencer and its consumers.
package rk16_pkg;

    localparam int RK16_W     = 16;
    localparam int RK16_CNT_W = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_NOT  = 4'b0001;
    localparam logic [3:0] ALU_SHL  = 4'b0010;
    localparam logic [3:0] ALU_ROL  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_SUB  = 4'b0111;
    localparam logic [3:0] ALU_EQ   = 4'b1000;
    localparam logic [3:0] ALU_NE   = 4'b1001;
    localparam logic [3:0] ALU_LT   = 4'b1010;
    localparam logic [3:0] ALU_LT2  = 4'b1011;
    localparam logic [3:0] ALU_LSR  = 4'b1100;
    localparam logic [3:0] ALU_ASR  = 4'b1101;
    localparam logic [3:0] ALU_ROR  = 4'b1110;
    localparam logic [3:0] ALU_ROR2 = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_seq_state_t;

    // Shift-class selects are iterated one bit per step by the sequencer.
    function automatic logic is_shift(input logic [3:0] sel);
        logic r;
        case (sel)
            ALU_SHL, ALU_ROL, ALU_LSR, ALU_ASR, ALU_ROR, ALU_ROR2: r = 1'b1;
            default:                                              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational RK16 alu: arithmetic, logic, compares and one-bit
// shifts/rotates. Compare results are 0x0000 or 0x0001.
module alu
    import rk16_pkg::*;
#(
    parameter int W = RK16_W
) (
    input  logic [3:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    // Decode the select into a single result; carries and borrows fall off the top.
    always_comb begin
        y = '0;
        case (sel)
            ALU_ADD:           y = a + b;
            ALU_NOT:           y = ~a;
            ALU_SHL:           y = {a[W-2:0], 1'b0};
            ALU_ROL:           y = {a[W-2:0], a[W-1]};
            ALU_AND:           y = a & b;
            ALU_XOR:           y = a ^ b;
            ALU_OR:            y = a | b;
            ALU_SUB:           y = a - b;
            ALU_EQ:            y = {{(W-1){1'b0}}, (a == b)};
            ALU_NE:            y = {{(W-1){1'b0}}, (a != b)};
            ALU_LT, ALU_LT2:   y = {{(W-1){1'b0}}, (a < b)};
            ALU_LSR:           y = {1'b0, a[W-1:1]};
            ALU_ASR:           y = {a[W-1], a[W-1:1]};
            ALU_ROR, ALU_ROR2: y = {a[0], a[W-1:1]};
            default:           y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute sequencer: accepts one op, iterates the one-bit alu
// for variable shifts/rotates of 0-15 bits, and returns the result.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE
// and out_data is held stable until out_ready is seen. in_valid is ignored
// whenever in_ready is low, and nothing is queued.
module alu_seq
    import rk16_pkg::*;
#(
    parameter int W     = RK16_W,
    parameter int CNT_W = RK16_CNT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     in_sel,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output alu_seq_state_t dbg_state
);

    alu_seq_state_t state;
    logic [3:0]     sel_q;
    logic [W-1:0]   acc;
    logic [CNT_W-1:0] cnt;

    logic [CNT_W-1:0] n;
    logic [3:0]       alu_sel;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [W-1:0]     alu_y;

    assign n = in_b[CNT_W-1:0];

    // Operand mux: IDLE feeds the incoming request, RUN feeds the accumulator;
    // b is forced to zero for every shift step.
    always_comb begin
        alu_sel = sel_q;
        alu_a   = acc;
        alu_b   = '0;
        if (state == IDLE) begin
            alu_sel = in_sel;
            alu_a   = in_a;
            if (!is_shift(in_sel)) begin
                alu_b = in_b;
            end
        end
    end

    alu #(.W(W)) u_alu (
        .sel (alu_sel),
        .a   (alu_a),
        .b   (alu_b),
        .y   (alu_y)
    );

    // Sequencer FSM: IDLE accepts, RUN iterates the shift, DONE waits for the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= ALU_ADD;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sel_q <= in_sel;
                        if (!is_shift(in_sel)) begin
                            acc   <= alu_y;
                            state <= DONE;
                        end else if (n == '0) begin
                            acc   <= in_a;
                            state <= DONE;
                        end else begin
                            acc   <= alu_y;
                            cnt   <= n - CNT_W'(1);
                            state <= (n == CNT_W'(1)) ? DONE : RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= alu_y;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus randomized ops checked against
// a shift-by-n arithmetic reference model.
module tb_alu_seq;
    import rk16_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_sel;
    logic [15:0]    in_a;
    logic [15:0]    in_b;
    logic           out_valid;
    logic           out_ready;
    logic [15:0]    out_data;
    alu_seq_state_t dbg_state;

    int checks;
    int failures;

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .dbg_state (dbg_state)
    );

    // Clock block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-count shifts computed directly, not stepwise.
    function automatic logic [15:0] ref_op(input logic [3:0] sel, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [31:0]        dbl;
        logic signed [15:0] sa;
        int                 n;
        n   = int'(b[3:0]);
        dbl = {a, a};
        sa  = a;
        case (sel)
            4'b0000: return a + b;
            4'b0001: return ~a;
            4'b0010: return a << n;
            4'b0011: begin dbl = dbl << n; return dbl[31:16]; end
            4'b0100: return a & b;
            4'b0101: return a ^ b;
            4'b0110: return a | b;
            4'b0111: return a - b;
            4'b1000: return (a == b) ? 16'd1 : 16'd0;
            4'b1001: return (a != b) ? 16'd1 : 16'd0;
            4'b1010, 4'b1011: return (a < b) ? 16'd1 : 16'd0;
            4'b1100: return a >> n;
            4'b1101: return 16'(sa >>> n);
            default: begin dbl = dbl >> n; return dbl[15:0]; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] sel, input logic [15:0] b);
        int n;
        n = int'(b[3:0]);
        if (sel inside {4'b0010, 4'b0011, 4'b1100, 4'b1101, 4'b1110, 4'b1111})
            return (n > 1) ? n : 1;
        return 1;
    endfunction

    // Driver: present a request in the current cycle (caller is #1 after an edge).
    task automatic issue(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sel   = sel;
        in_a     = a;
        in_b     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    // Wait for out_valid (bounded), then check latency and data; leaves DONE pending.
    task automatic wait_result(input string tag, input logic [15:0] exp_data, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(out_data), 32'(exp_data));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    endtask

    // Complete the result handshake and confirm the return to IDLE.
    task automatic drain(input string tag, input logic [15:0] exp_data);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_hold"}, 32'(out_data), 32'(exp_data));
    endtask

    task automatic run_op(input string tag, input logic [3:0] sel, input logic [15:0] a,
                          input logic [15:0] b);
        logic [15:0] e;
        e = ref_op(sel, a, b);
        issue(sel, a, b);
        wait_result(tag, e, ref_lat(sel, b));
        drain(tag, e);
    endtask

    initial begin
        logic [15:0] held;
        logic [3:0]  rs;
        logic [15:0] ra;
        logic [15:0] rb;
        int          seen;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 4'd0;
        in_a      = 16'd0;
        in_b      = 16'd0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD with in_ready low until handshake.
        issue(4'b0000, 16'h1234, 16'h0FF0);
        check("add_c1_in_ready", 32'(in_ready), 32'd0);
        wait_result("add", 16'h2224, 1);
        drain("add", 16'h2224);

        // ASR by 4, ROL by 15, unsigned lt, count zero.
        run_op("asr4", 4'b1101, 16'h8000, 16'h0004);
        check("asr4_model", 32'(ref_op(4'b1101, 16'h8000, 16'h0004)), 32'h0000F800);
        run_op("rol15", 4'b0011, 16'h0001, 16'h000F);
        check("rol15_model", 32'(ref_op(4'b0011, 16'h0001, 16'h000F)), 32'h00008000);
        run_op("ltu", 4'b1010, 16'h0001, 16'hFFFF);
        run_op("shl0", 4'b0010, 16'hABCD, 16'h0010);
        run_op("ror1", 4'b1110, 16'h0001, 16'h0001);
        run_op("sub_wrap", 4'b0111, 16'h0000, 16'h0001);

        // Backpressure: result held, in_valid pulse during DONE ignored.
        issue(4'b0101, 16'hF0F0, 16'h3C3C);
        wait_result("bp", 16'hCCCC, 1);
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1);
            in_sel   = 4'b0000;
            in_a     = 16'h1111;
            in_b     = 16'h2222;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'(held));
        end
        drain("bp", 16'hCCCC);

        // Reset mid-RUN: LSR by 10, rst_n low at the cycle-3 edge.
        issue(4'b1100, 16'hFFFF, 16'h000A);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        run_op("post_rst_add", 4'b0000, 16'h7FFF, 16'h0001);

        // Randomized ops against the reference model.
        for (int k = 0; k < 40; k++) begin
            rs = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k % 5 == 0) rb = ra;
            run_op("rand", rs, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
